// File: rtl/dvp_pixel_capture.sv
// DVP camera capture: pairs bytes into RGB565 pixels and polices the frame geometry.
// Latency: pixel visible one cycle after its second byte is sampled; frame_done one cycle after vsync.
// Backpressure: none; every data_valid_out must be consumed.
module dvp_pixel_capture #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter logic        VSYNC_POL  = 1'b1,
    parameter logic        HI_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] pixel_out,
    output logic        data_valid_out,
    output logic        frame_start,
    output logic        frame_done,
    output logic [9:0]  x_count,
    output logic [9:0]  y_count,
    output logic        line_len_err,
    output logic        frame_len_err
);

    localparam logic [9:0] W = 10'(IMG_WIDTH);
    localparam logic [9:0] H = 10'(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, SYNC_WAIT, BLANK, CAPTURE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        frame_begin;
    logic        frame_end;
    logic        vs_act;
    logic        byte_in;
    logic        line_end;
    logic        href_q;
    logic        phase;
    logic [7:0]  first_byte;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [9:0]  row_nxt;
    logic [15:0] pix;

    assign vs_act   = (cam_vsync == VSYNC_POL);
    assign byte_in  = (state_q == CAPTURE) && cam_href && !vs_act;
    // A line closes when href drops, or when vsync cuts it off while still open.
    assign line_end = href_q && !byte_in;
    assign row_nxt  = (line_end && (row < H)) ? row + 10'd1 : row;
    assign pix      = HI_FIRST ? {first_byte, cam_data} : {cam_data, first_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_begin = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SYNC_WAIT;
                end
            end
            SYNC_WAIT: begin
                if (vs_act) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (!vs_act) begin
                    if (enable) begin
                        state_d     = CAPTURE;
                        frame_begin = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CAPTURE: begin
                if (vs_act) begin
                    state_d   = BLANK;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out      <= 16'd0;
            data_valid_out <= 1'b0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            x_count        <= 10'd0;
            y_count        <= 10'd0;
            line_len_err   <= 1'b0;
            frame_len_err  <= 1'b0;
            href_q         <= 1'b0;
            phase          <= 1'b0;
            first_byte     <= 8'd0;
            col            <= 10'd0;
            row            <= 10'd0;
        end else begin
            data_valid_out <= 1'b0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            href_q         <= byte_in;

            if (frame_begin) begin
                line_len_err  <= 1'b0;
                frame_len_err <= 1'b0;
                col           <= 10'd0;
                row           <= 10'd0;
                phase         <= 1'b0;
            end

            if (byte_in) begin
                if (!phase) begin
                    first_byte <= cam_data;
                    phase      <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if ((row < H) && (col < W)) begin
                        pixel_out      <= pix;
                        x_count        <= col;
                        y_count        <= row;
                        data_valid_out <= 1'b1;
                        frame_start    <= (col == 10'd0) && (row == 10'd0);
                    end else if (row >= H) begin
                        frame_len_err <= 1'b1;
                    end else begin
                        line_len_err <= 1'b1;
                    end
                    // Column keeps counting on dropped rows so a full-width extra line is not a line error.
                    if (col < W) begin
                        col <= col + 10'd1;
                    end
                end
            end

            if (line_end) begin
                if (phase || (col != W)) begin
                    line_len_err <= 1'b1;
                end
                row   <= row_nxt;
                col   <= 10'd0;
                phase <= 1'b0;
            end

            if (frame_end) begin
                frame_done <= 1'b1;
                if (row_nxt != H) begin
                    frame_len_err <= 1'b1;
                end
            end
        end
    end

endmodule
